// File: rtl/dc_req_pkg.sv
// Shared types and address-field layout for the DC data-bank requester.
// Holds the op encoding, the bank beat format and the requester FSM states.
package dc_req_pkg;

  localparam int NBANKS_DEF = 16;
  localparam int AW_DEF     = 12;

  localparam int BANK_LSB  = 2;
  localparam int BANK_MSB  = 5;
  localparam int INDEX_LSB = 6;
  localparam int INDEX_MSB = 10;
  localparam int ROW_BIT   = 11;

  typedef enum logic [2:0] {
    OP_LD32 = 3'd0,
    OP_LD64 = 3'd1,
    OP_ST32 = 3'd2,
    OP_ST64 = 3'd3,
    OP_INV  = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } req_state_e;

  typedef struct packed {
    logic [3:0]  valid;
    logic [31:0] data;
  } beat_t;

endpackage

// File: rtl/dc_addr_field_decode.sv
// Combinational split of a byte address into bank one-hot, index and row,
// plus the illegal/misaligned op check; zero latency, no flow control.
module dc_addr_field_decode
  import dc_req_pkg::*;
#(
  parameter int NBANKS = NBANKS_DEF,
  parameter int AW     = AW_DEF,
  localparam int BW    = $clog2(NBANKS)
) (
  input  logic [AW-1:0]     addr,
  input  logic [2:0]        op,
  input  logic [BW-1:0]     beat,
  output logic [NBANKS-1:0] bank_sel,
  output logic [4:0]        index,
  output logic              row,
  output logic              err
);

  logic [BW-1:0] bank_num;
  logic          is_x64;
  logic          unused_byte;

  assign is_x64 = (op == OP_LD64) || (op == OP_ST64);

  // 64-bit ops cover an even/odd bank pair; the beat picks the half.
  always_comb begin
    bank_num = addr[BANK_MSB:BANK_LSB];
    if (is_x64) begin
      bank_num = {addr[BANK_MSB:BANK_LSB+1], beat[0]};
    end else if (op == OP_INV) begin
      bank_num = beat;
    end
  end

  assign bank_sel    = NBANKS'(1) << bank_num;
  assign index       = addr[INDEX_MSB:INDEX_LSB];
  assign row         = addr[ROW_BIT];
  assign err         = (op > OP_INV) || (is_x64 && addr[2]);
  assign unused_byte = ^addr[1:0];

endmodule

// File: rtl/dc_bank_requester.sv
// Core-to-databank requester: one op in flight, 1/2/NBANKS bank beats, one core response.
// Latency x32 3, x64 5, INV 2*NBANKS+1 cycles; bank/core retry hold the current beat/response stable.
module dc_bank_requester
  import dc_req_pkg::*;
#(
  parameter int NBANKS = NBANKS_DEF,
  parameter int AW     = AW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req_valid,
  output logic              core_req_retry,
  input  logic [2:0]        core_req_op,
  input  logic [AW-1:0]     core_req_addr,
  input  logic [2:0]        core_req_way,
  input  logic [63:0]       core_req_data,
  input  logic [7:0]        core_req_mask,
  output logic              core_ack_valid,
  input  logic              core_ack_retry,
  output logic [63:0]       core_ack_data,
  output logic              core_ack_miss,
  output logic              core_ack_err,
  output logic [NBANKS-1:0] bank_sel,
  output logic              bank_req_valid,
  input  logic              bank_req_retry,
  output logic              bank_write,
  output logic [2:0]        bank_way_no,
  output logic              bank_row_even_odd,
  output logic [4:0]        bank_req_index,
  output logic [35:0]       bank_req_data,
  input  logic              bank_ack_valid,
  output logic              bank_ack_retry,
  input  logic [35:0]       bank_ack_data
);

  localparam int BW = $clog2(NBANKS);

  req_state_e    state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [2:0]    way_q, way_d;
  logic [63:0]   wdata_q, wdata_d;
  logic [7:0]    mask_q, mask_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [63:0]   rdata_q, rdata_d;
  logic          miss_q, miss_d;
  logic          err_q, err_d;

  logic [AW-1:0]     dec_addr;
  logic [2:0]        dec_op;
  logic [NBANKS-1:0] dec_sel;
  logic [4:0]        dec_index;
  logic              dec_row;
  logic              dec_err;
  logic [BW-1:0]     last_beat;
  logic              is_load;
  logic              is_write;
  beat_t             ack_beat;

  // The error check needs the live op at acceptance; every other cycle sees registers only.
  assign dec_addr = (state_q == S_IDLE) ? core_req_addr : addr_q;
  assign dec_op   = (state_q == S_IDLE) ? core_req_op   : op_q;
  assign ack_beat = bank_ack_data;

  dc_addr_field_decode #(.NBANKS(NBANKS), .AW(AW)) u_decode (
    .addr     (dec_addr),
    .op       (dec_op),
    .beat     (beat_q),
    .bank_sel (dec_sel),
    .index    (dec_index),
    .row      (dec_row),
    .err      (dec_err)
  );

  assign is_load  = (op_q == OP_LD32) || (op_q == OP_LD64);
  assign is_write = (op_q == OP_ST32) || (op_q == OP_ST64) || (op_q == OP_INV);

  always_comb begin
    last_beat = '0;
    case (op_q)
      OP_LD64, OP_ST64: last_beat = BW'(1);
      OP_INV:           last_beat = BW'(NBANKS - 1);
      default:          last_beat = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    way_d   = way_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    beat_d  = beat_q;
    rdata_d = rdata_q;
    miss_d  = miss_q;
    err_d   = err_q;

    core_req_retry    = reset || (state_q != S_IDLE);
    core_ack_valid    = 1'b0;
    bank_req_valid    = 1'b0;
    bank_ack_retry    = 1'b1;
    bank_sel          = '0;
    bank_write        = 1'b0;
    bank_way_no       = '0;
    bank_row_even_odd = 1'b0;
    bank_req_index    = '0;
    bank_req_data     = '0;
    core_ack_data     = '0;
    core_ack_miss     = 1'b0;
    core_ack_err      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (core_req_valid) begin
          op_d    = core_req_op;
          addr_d  = core_req_addr;
          way_d   = core_req_way;
          wdata_d = core_req_data;
          mask_d  = core_req_mask;
          beat_d  = '0;
          rdata_d = '0;
          miss_d  = 1'b0;
          err_d   = dec_err;
          state_d = dec_err ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        bank_req_valid    = 1'b1;
        bank_sel          = dec_sel;
        bank_write        = is_write;
        bank_way_no       = way_q;
        bank_row_even_odd = dec_row;
        bank_req_index    = dec_index;
        if (op_q != OP_INV) begin
          bank_req_data = beat_q[0] ? {mask_q[7:4], wdata_q[63:32]}
                                    : {mask_q[3:0], wdata_q[31:0]};
        end
        if (!bank_req_retry) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        bank_ack_retry = 1'b0;
        if (bank_ack_valid) begin
          if (is_load) begin
            if (beat_q[0]) rdata_d[63:32] = ack_beat.data;
            else           rdata_d[31:0]  = ack_beat.data;
            miss_d = miss_q || (ack_beat.valid != 4'hF);
          end
          // Counter stops at the last beat so it never wraps mid-op.
          if (beat_q == last_beat) begin
            state_d = S_RESP;
          end else begin
            beat_d  = beat_q + BW'(1);
            state_d = S_ISSUE;
          end
        end
      end
      S_RESP: begin
        core_ack_valid = 1'b1;
        core_ack_data  = rdata_q;
        core_ack_miss  = miss_q;
        core_ack_err   = err_q;
        if (!core_ack_retry) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      way_q   <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      beat_q  <= '0;
      rdata_q <= '0;
      miss_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      way_q   <= way_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      beat_q  <= beat_d;
      rdata_q <= rdata_d;
      miss_q  <= miss_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_dc_bank_requester.sv
// Directed vector bench for dc_bank_requester: a table of whole ops with a simple
// bank responder, plus hand sequences for stalls, error hold and mid-op reset.
module tb_dc_bank_requester;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_req_valid;
  logic        core_req_retry;
  logic [2:0]  core_req_op;
  logic [11:0] core_req_addr;
  logic [2:0]  core_req_way;
  logic [63:0] core_req_data;
  logic [7:0]  core_req_mask;
  logic        core_ack_valid;
  logic        core_ack_retry;
  logic [63:0] core_ack_data;
  logic        core_ack_miss;
  logic        core_ack_err;
  logic [15:0] bank_sel;
  logic        bank_req_valid;
  logic        bank_req_retry;
  logic        bank_write;
  logic [2:0]  bank_way_no;
  logic        bank_row_even_odd;
  logic [4:0]  bank_req_index;
  logic [35:0] bank_req_data;
  logic        bank_ack_valid;
  logic        bank_ack_retry;
  logic [35:0] bank_ack_data;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dc_bank_requester #(.NBANKS(16), .AW(12)) dut (
    .clk               (clk),
    .reset             (reset),
    .core_req_valid    (core_req_valid),
    .core_req_retry    (core_req_retry),
    .core_req_op       (core_req_op),
    .core_req_addr     (core_req_addr),
    .core_req_way      (core_req_way),
    .core_req_data     (core_req_data),
    .core_req_mask     (core_req_mask),
    .core_ack_valid    (core_ack_valid),
    .core_ack_retry    (core_ack_retry),
    .core_ack_data     (core_ack_data),
    .core_ack_miss     (core_ack_miss),
    .core_ack_err      (core_ack_err),
    .bank_sel          (bank_sel),
    .bank_req_valid    (bank_req_valid),
    .bank_req_retry    (bank_req_retry),
    .bank_write        (bank_write),
    .bank_way_no       (bank_way_no),
    .bank_row_even_odd (bank_row_even_odd),
    .bank_req_index    (bank_req_index),
    .bank_req_data     (bank_req_data),
    .bank_ack_valid    (bank_ack_valid),
    .bank_ack_retry    (bank_ack_retry),
    .bank_ack_data     (bank_ack_data)
  );

  typedef struct {
    logic [2:0]  op;
    logic [11:0] addr;
    logic [2:0]  way;
    logic [63:0] wdata;
    logic [7:0]  mask;
    logic [35:0] ack0;
    logic [35:0] ack1;
    int          nbeats;
    int          bank0;
    logic [4:0]  idx;
    logic        row;
    logic        wr;
    logic        chk_rdata;
    logic [63:0] rdata;
    logic        miss;
    logic        err;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [2:0] op, input logic [11:0] addr, input logic [2:0] way,
                          input logic [63:0] wdata, input logic [7:0] mask);
    core_req_op    = op;
    core_req_addr  = addr;
    core_req_way   = way;
    core_req_data  = wdata;
    core_req_mask  = mask;
    core_req_valid = 1'b1;
  endtask

  task automatic run_op(input int k);
    vec_t v;
    int beats;
    bit got;
    bit pend;
    logic [35:0] exp_rd;
    v = vecs[k];
    drive_op(v.op, v.addr, v.way, v.wdata, v.mask);
    chk($sformatf("v%0d_req_accept", k), 64'(core_req_retry), 64'(0));
    tick();
    core_req_valid = 1'b0;
    beats = 0;
    got   = 1'b0;
    pend  = 1'b0;
    for (int cyc = 0; cyc < 200 && !got; cyc++) begin
      if (core_ack_valid) begin
        chk($sformatf("v%0d_err", k), 64'(core_ack_err), 64'(v.err));
        if (v.chk_rdata) begin
          chk($sformatf("v%0d_rdata", k), core_ack_data, v.rdata);
          chk($sformatf("v%0d_miss", k), 64'(core_ack_miss), 64'(v.miss));
        end
        got = 1'b1;
      end else if (bank_req_valid) begin
        chk($sformatf("v%0d_b%0d_sel", k, beats), 64'(bank_sel), 64'(16'(1) << (v.bank0 + beats)));
        chk($sformatf("v%0d_b%0d_idx", k, beats), 64'(bank_req_index), 64'(v.idx));
        chk($sformatf("v%0d_b%0d_row", k, beats), 64'(bank_row_even_odd), 64'(v.row));
        chk($sformatf("v%0d_b%0d_wr", k, beats), 64'(bank_write), 64'(v.wr));
        chk($sformatf("v%0d_b%0d_way", k, beats), 64'(bank_way_no), 64'(v.way));
        if (v.wr) begin
          if (v.op == 3'd4) exp_rd = 36'h0;
          else if (beats == 0) exp_rd = {v.mask[3:0], v.wdata[31:0]};
          else exp_rd = {v.mask[7:4], v.wdata[63:32]};
          chk($sformatf("v%0d_b%0d_wdata", k, beats), 64'(bank_req_data), 64'(exp_rd));
        end
        beats++;
        pend = 1'b1;
      end else if (pend && !bank_ack_retry) begin
        bank_ack_valid = 1'b1;
        bank_ack_data  = (beats == 1) ? v.ack0 : v.ack1;
        pend = 1'b0;
      end
      tick();
      bank_ack_valid = 1'b0;
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL v%0d_timeout no core ack within 200 cycles", k);
    end
    chk($sformatf("v%0d_beats", k), 64'(beats), 64'(v.nbeats));
    chk($sformatf("v%0d_idle_after", k), 64'(core_ack_valid), 64'(0));
  endtask

  initial begin
    //          op    addr     way  wdata                  mask   ack0            ack1            n   bank0 idx    row  wr   chk  rdata                   miss err
    vecs[0] = '{3'd1, 12'h010, 3'd2, 64'h0,                8'h00, 36'hF_11111111, 36'h7_22222222, 2,  4,   5'd0,  1'b0, 1'b0, 1'b1, 64'h22222222_11111111, 1'b1, 1'b0};
    vecs[1] = '{3'd0, 12'h8C4, 3'd3, 64'h0,                8'h00, 36'hF_DEADBEEF, 36'h0,          1,  1,   5'd3,  1'b1, 1'b0, 1'b1, 64'h00000000_DEADBEEF, 1'b0, 1'b0};
    vecs[2] = '{3'd0, 12'h03C, 3'd7, 64'h0,                8'h00, 36'hE_0BADF00D, 36'h0,          1,  15,  5'd0,  1'b0, 1'b0, 1'b1, 64'h00000000_0BADF00D, 1'b1, 1'b0};
    vecs[3] = '{3'd3, 12'h7F8, 3'd5, 64'hCAFEF00D_12345678, 8'hA5, 36'h0,          36'h0,          2,  14,  5'd31, 1'b0, 1'b1, 1'b0, 64'h0,                 1'b0, 1'b0};
    vecs[4] = '{3'd4, 12'h7C0, 3'd1, 64'h0,                8'h00, 36'h0,          36'h0,          16, 0,   5'd31, 1'b0, 1'b1, 1'b0, 64'h0,                 1'b0, 1'b0};
    vecs[5] = '{3'd6, 12'h000, 3'd0, 64'h0,                8'h00, 36'h0,          36'h0,          0,  0,   5'd0,  1'b0, 1'b0, 1'b1, 64'h0,                 1'b0, 1'b1};
    vecs[6] = '{3'd1, 12'h004, 3'd0, 64'h0,                8'h00, 36'h0,          36'h0,          0,  0,   5'd0,  1'b0, 1'b0, 1'b1, 64'h0,                 1'b0, 1'b1};

    reset          = 1'b1;
    core_req_valid = 1'b0;
    core_req_op    = '0;
    core_req_addr  = '0;
    core_req_way   = '0;
    core_req_data  = '0;
    core_req_mask  = '0;
    core_ack_retry = 1'b0;
    bank_req_retry = 1'b0;
    bank_ack_valid = 1'b0;
    bank_ack_data  = '0;
    tick();
    tick();
    chk("rst_core_req_retry", 64'(core_req_retry), 64'(1));
    chk("rst_bank_ack_retry", 64'(bank_ack_retry), 64'(1));
    chk("rst_core_ack_valid", 64'(core_ack_valid), 64'(0));
    chk("rst_bank_req_valid", 64'(bank_req_valid), 64'(0));
    chk("rst_bank_sel", 64'(bank_sel), 64'(0));
    chk("rst_core_ack_data", core_ack_data, 64'(0));
    reset = 1'b0;
    tick();

    for (int k = 0; k < 7; k++) run_op(k);

    // ST32 under bank stall; stray acks during ISSUE must be refused and ignored.
    bank_req_retry = 1'b1;
    drive_op(3'd2, 12'h008, 3'd4, 64'h0_A5A5A5A5, 8'h03);
    tick();
    core_req_valid = 1'b0;
    bank_ack_valid = 1'b1;
    bank_ack_data  = 36'hF_00000000;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("st_stall%0d_vld", i), 64'(bank_req_valid), 64'(1));
      chk($sformatf("st_stall%0d_data", i), 64'(bank_req_data), 64'(36'h3_A5A5A5A5));
      chk($sformatf("st_stall%0d_sel", i), 64'(bank_sel), 64'(16'h0004));
      chk($sformatf("st_stall%0d_ackrty", i), 64'(bank_ack_retry), 64'(1));
      tick();
    end
    bank_ack_valid = 1'b0;
    bank_req_retry = 1'b0;
    chk("st_release_vld", 64'(bank_req_valid), 64'(1));
    chk("st_release_wr", 64'(bank_write), 64'(1));
    tick();
    chk("st_single_write", 64'(bank_req_valid), 64'(0));
    bank_ack_valid = 1'b1;
    bank_ack_data  = 36'h0_12345678;
    tick();
    bank_ack_valid = 1'b0;
    chk("st_ack_vld", 64'(core_ack_valid), 64'(1));
    chk("st_ack_err", 64'(core_ack_err), 64'(0));
    tick();

    // Illegal op with the core stalling its response for two cycles.
    core_ack_retry = 1'b1;
    drive_op(3'd6, 12'h000, 3'd0, 64'h0, 8'h00);
    tick();
    core_req_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("err_hold%0d_vld", i), 64'(core_ack_valid), 64'(1));
      chk($sformatf("err_hold%0d_err", i), 64'(core_ack_err), 64'(1));
      chk($sformatf("err_hold%0d_data", i), core_ack_data, 64'(0));
      chk($sformatf("err_hold%0d_nobank", i), 64'(bank_req_valid), 64'(0));
      chk($sformatf("err_hold%0d_busy", i), 64'(core_req_retry), 64'(1));
      tick();
    end
    core_ack_retry = 1'b0;
    tick();
    chk("err_released", 64'(core_ack_valid), 64'(0));
    chk("err_idle", 64'(core_req_retry), 64'(0));

    // Reset while waiting on beat 0 of an LD64.
    drive_op(3'd1, 12'h010, 3'd2, 64'h0, 8'h00);
    tick();
    core_req_valid = 1'b0;
    chk("mid_issue", 64'(bank_req_valid), 64'(1));
    tick();
    chk("mid_wait_ackrdy", 64'(bank_ack_retry), 64'(0));
    reset = 1'b1;
    tick();
    chk("mid_rst_reqrty", 64'(core_req_retry), 64'(1));
    chk("mid_rst_ackrty", 64'(bank_ack_retry), 64'(1));
    chk("mid_rst_noack", 64'(core_ack_valid), 64'(0));
    chk("mid_rst_noreq", 64'(bank_req_valid), 64'(0));
    reset = 1'b0;
    tick();
    chk("mid_idle", 64'(core_req_retry), 64'(0));
    chk("mid_no_resp", 64'(core_ack_valid), 64'(0));
    run_op(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
